// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte producers,
// launching one frame at a time and guarding each frame with a watchdog.
module uart_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16384,
   localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CNT_W         = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                        sysclk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        o_tx_start,
   output logic [DATA_WIDTH-1:0]       o_tx_byte,
   input  logic                        i_tx_done,
   output logic                        busy,
   output logic [ID_W-1:0]             grant_id,
   output logic                        timeout_err,
   input  logic                        err_clr,
   output logic [1:0]                  dbg_state
);

   // Handshake: a byte moves on the rising edge where req_valid[i] & req_ready[i];
   // req_ready is one-hot, only ever asserted in IDLE, and a requester holds
   // req_data stable while its req_valid is high.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   logic [ID_W-1:0]         last;
   logic [CNT_W-1:0]        wd_cnt;
   logic [ID_W-1:0]         winner;
   logic [ID_W-1:0]         cand;
   logic                    found;
   logic [DATA_WIDTH-1:0]   sel_byte;

   // Search starts just after the last winner so a held request waits at most N_REQ-1 grants.
   always_comb begin
      winner = last;
      cand   = last;
      found  = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(last) + k) % N_REQ);
         if (!found && req_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // Gated with rst_n so no strobe escapes while the block is held in reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == S_IDLE && found) req_ready[winner] = 1'b1;
   end

   assign sel_byte  = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
   assign dbg_state = state;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         last        <= ID_W'(N_REQ - 1);
         wd_cnt      <= '0;
         o_tx_start  <= 1'b0;
         o_tx_byte   <= '0;
         busy        <= 1'b0;
         grant_id    <= '0;
         timeout_err <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         if (err_clr) timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  o_tx_byte  <= sel_byte;
                  grant_id   <= winner;
                  last       <= winner;
                  o_tx_start <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               wd_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               // Done has priority over an expiring watchdog in the same cycle.
               if (i_tx_done) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (wd_cnt == WD_LIMIT) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed producers, a timeline model of each frame,
// per-cycle output comparison plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int T = 64;

   // ---------------- clock / reset / DUT ----------------
   logic           sysclk = 1'b0;
   logic           rst_n  = 1'b0;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           o_tx_start;
   logic [W-1:0]   o_tx_byte;
   logic           i_tx_done;
   logic           busy;
   logic [1:0]     grant_id;
   logic           timeout_err;
   logic           err_clr;
   logic [1:0]     dbg_state;

   always #5 sysclk = ~sysclk;

   uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte),
      .i_tx_done(i_tx_done), .busy(busy), .grant_id(grant_id),
      .timeout_err(timeout_err), .err_clr(err_clr), .dbg_state(dbg_state)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- producers and done source ----------------
   logic [W-1:0] pq [N][$];
   logic [N-1:0] vmask;
   int           done_delay;
   bit           stray_idle, stray_start, clr_req;
   int           rand_done_div;

   // ---------------- behavioural model ----------------
   // A frame is described by its age: 1 in the launch cycle, then waiting cycles;
   // the watchdog count during waiting is age-2.
   bit           m_active;
   int           m_age;
   int           m_last;
   logic [W-1:0] m_byte;
   int           m_grant;
   bit           m_err;
   logic [W-1:0] exp_q[$];
   int           mw;
   bit           mset;

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = (pq[i].size() > 0) && vmask[i];
         req_data[i*W +: W] = (pq[i].size() > 0) ? pq[i][0] : '0;
      end
      if (rand_done_div > 0)
         i_tx_done = ($urandom_range(rand_done_div - 1, 0) == 0);
      else
         i_tx_done = (m_active && m_age == 1 + done_delay) ||
                     (stray_start && m_active && m_age == 1) ||
                     (stray_idle && !m_active);
      err_clr = clr_req;
   endtask

   always @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0; m_age = 0; m_last = N - 1; m_byte = '0;
         m_grant = 0; m_err = 1'b0; exp_q.delete();
      end else begin
         mset = 1'b0;
         if (!m_active) begin
            mw = rr_pick(req_valid, m_last);
            if (mw >= 0) begin
               m_byte = req_data[mw*W +: W];
               m_grant = mw; m_last = mw; m_active = 1'b1; m_age = 1;
               exp_q.push_back(m_byte);
               void'(pq[mw].pop_front());
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else if (i_tx_done) begin
            m_active = 1'b0;
         end else if (m_age - 2 == T - 1) begin
            mset = 1'b1; m_active = 1'b0;
         end else begin
            m_age++;
         end
         if (mset) m_err = 1'b1;
         else if (err_clr) m_err = 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge sysclk) begin
      int ew;
      logic [N-1:0] er;
      ew = rr_pick(req_valid, m_last);
      er = '0;
      if (rst_n && !m_active && ew >= 0) er[ew] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("busy", busy, m_active);
      chk("tx_start", o_tx_start, m_active && m_age == 1);
      chk("tx_byte", o_tx_byte, m_byte);
      chk("grant_id", grant_id, m_grant);
      chk("timeout_err", timeout_err, m_err);
      if (o_tx_start) begin
         if (exp_q.size() == 0) chk("launch_unexpected", 1, 0);
         else chk("launch_byte", o_tx_byte, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge sysclk);
      #1;
      drive_inputs();
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) pq[i].delete();
      vmask = '1; done_delay = 1000; stray_idle = 0; stray_start = 0;
      rand_done_div = 0; clr_req = 0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic wait_start(input string nm);
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step();
         if (o_tx_start) ok = 1;
      end
      chk(nm, ok, 1);
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step();
         if (!busy) ok = 1;
      end
      chk(nm, ok, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ---------------- directed and random scenarios ----------------
   initial begin
      int s_cyc, d_cyc, n_starts;
      int ids[$], bytes[$], starts[$], dones[$];
      int exp_ids[5];
      req_valid = '0; req_data = '0; i_tx_done = 0; err_clr = 0;
      vmask = '1; done_delay = 1000; stray_idle = 0; stray_start = 0;
      rand_done_div = 0; clr_req = 0;
      exp_ids = '{0, 1, 2, 3, 0};

      // reset values
      apply_reset();
      chk("rst_busy", busy, 0);
      chk("rst_byte", o_tx_byte, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_ready", req_ready, 0);

      // single request
      done_delay = 20;
      pq[2].push_back(8'hA5);
      step();
      chk("single_ready", req_ready, 4'b0100);
      step();
      chk("single_start", o_tx_start, 1);
      chk("single_byte", o_tx_byte, 8'hA5);
      chk("single_grant", grant_id, 2);
      chk("single_ready_drop", req_ready, 0);
      d_cyc = 0;
      for (int i = 0; i < 100 && !i_tx_done; i++) step();
      chk("single_done_seen", i_tx_done, 1);
      step();
      chk("single_busy_fall", busy, 0);

      // round-robin fairness
      apply_reset();
      done_delay = 20;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) pq[i].push_back(8'h10 + 8'(i));
      for (int i = 0; i < 400 && ids.size() < 5; i++) begin
         step();
         if (o_tx_start) begin
            ids.push_back(int'(grant_id)); bytes.push_back(int'(o_tx_byte)); starts.push_back(cyc);
         end
         if (i_tx_done && busy) dones.push_back(cyc);
      end
      chk("fair_count", ids.size(), 5);
      if (ids.size() == 5 && dones.size() >= 4) begin
         for (int k = 0; k < 5; k++) begin
            chk("fair_order", ids[k], exp_ids[k]);
            chk("fair_byte", bytes[k], 8'h10 + exp_ids[k]);
         end
         for (int k = 0; k < 4; k++) chk("fair_spacing", starts[k+1] - dones[k], 2);
      end

      // watchdog timeout, next requester, then clear
      apply_reset();
      pq[0].push_back(8'h3C);
      pq[1].push_back(8'h4D);
      wait_start("to_first_start");
      s_cyc = cyc;
      for (int i = 0; i < 200 && !timeout_err; i++) step();
      // flag is set on the 64th edge after the launch cycle ends
      chk("to_latency", cyc - s_cyc, 65);
      chk("to_idle", busy, 0);
      chk("to_next_ready", req_ready, 4'b0010);
      step();
      chk("to_next_start", o_tx_start, 1);
      chk("to_next_grant", grant_id, 1);
      chk("to_next_byte", o_tx_byte, 8'h4D);
      done_delay = 5;
      wait_idle("to_second_idle");
      chk("to_sticky", timeout_err, 1);
      clr_req = 1;
      step();
      clr_req = 0;
      step();
      chk("to_cleared", timeout_err, 0);

      // done and watchdog limit in the same cycle
      apply_reset();
      done_delay = 64;
      pq[0].push_back(8'h5A);
      wait_start("sim_start");
      s_cyc = cyc;
      d_cyc = 0;
      for (int i = 0; i < 200 && busy; i++) begin
         step();
         if (i_tx_done) d_cyc = cyc;
      end
      chk("sim_done_at_limit", d_cyc - s_cyc, 64);
      chk("sim_idle", busy, 0);
      chk("sim_no_err", timeout_err, 0);

      // stray done in IDLE and START
      apply_reset();
      stray_idle = 1;
      n_starts = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (o_tx_start || busy) n_starts++;
      end
      chk("stray_idle_quiet", n_starts, 0);
      stray_idle = 0; stray_start = 1; done_delay = 10;
      pq[3].push_back(8'h77);
      step();
      step();
      chk("stray_start_launch", o_tx_start, 1);
      chk("stray_start_done", i_tx_done, 1);
      step();
      chk("stray_still_busy", busy, 1);
      n_starts = 0;
      for (int i = 0; i < 50 && busy; i++) begin
         step();
         if (o_tx_start) n_starts++;
      end
      chk("stray_no_extra", n_starts, 0);
      chk("stray_idle_end", busy, 0);
      stray_start = 0;

      // reset in the middle of a frame
      apply_reset();
      done_delay = 40;
      pq[2].push_back(8'hC3);
      wait_start("mid_start");
      repeat (5) step();
      chk("mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_byte", o_tx_byte, 0);
      chk("mid_grant", grant_id, 0);
      chk("mid_start_low", o_tx_start, 0);
      pq[1].push_back(8'h11);
      pq[3].push_back(8'h33);
      drive_inputs();
      #1;
      chk("mid_ready_in_reset", req_ready, 0);
      step();
      step();
      rst_n = 1'b1;
      wait_start("mid_restart");
      chk("mid_first_grant", grant_id, 1);
      chk("mid_first_byte", o_tx_byte, 8'h11);
      wait_idle("mid_idle");

      // randomized traffic, frequent done
      apply_reset();
      rand_done_div = 12;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            int r = $urandom_range(0, N - 1);
            if (pq[r].size() < 4) pq[r].push_back(8'($urandom_range(0, 255)));
         end
         for (int j = 0; j < N; j++) vmask[j] = ($urandom_range(0, 3) != 0);
         clr_req = ($urandom_range(0, 40) == 0);
         step();
      end

      // randomized traffic, rare done so the watchdog fires
      rand_done_div = 200;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            int r = $urandom_range(0, N - 1);
            if (pq[r].size() < 4) pq[r].push_back(8'($urandom_range(0, 255)));
         end
         vmask = '1;
         clr_req = ($urandom_range(0, 60) == 0);
         step();
      end

      rand_done_div = 0; clr_req = 0;
      for (int i = 0; i < N; i++) pq[i].delete();
      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter between `N_REQ` byte producers, such as a switch-driven message source, a receive echo path and a status reporter. It accepts one byte at a time from a requester over a valid/ready handshake and launches the transmitter. It then waits for the transmitter's done pulse before granting the next requester. A watchdog aborts a frame if the transmitter never reports completion. The block sits between the producers and `uart_tx` inside `uart_top`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, `` `DATA_WIDTH `` (8), byte width
- `TIMEOUT_CYCLES`, 16384, maximum sysclk cycles from launch to done; must exceed one frame (10 bit times)

- `sysclk`  in  1  system clock, all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester byte available
- `req_data`  in  N_REQ*DATA_WIDTH  requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  N_REQ  one-hot acceptance strobe; the transfer occurs on the edge where valid & ready
- `o_tx_start`  out  1  one-cycle launch pulse to `uart_tx`
- `o_tx_byte`  out  DATA_WIDTH  byte to transmit; stable from launch until return to IDLE
- `i_tx_done`  in  1  one-cycle pulse from `uart_tx` after the stop bit
- `busy`  out  1  high whenever state ≠ IDLE
- `grant_id`  out  clog2(N_REQ)  index of the most recently granted requester
- `timeout_err`  out  1  sticky watchdog flag
- `err_clr`  in  1  synchronous clear of `timeout_err`

## Operation
- FSM states: IDLE, START, WAIT.
- **IDLE:**
  - If any `req_valid` is high, select a winner by round-robin, searching from `last+1` upward with wrap-around.
  - `req_ready[winner]` is driven combinationally in this cycle. At the edge, capture the winner's byte into `o_tx_byte`, set `grant_id` and `last` to the winner, and move to START.
  - If no `req_valid` is high, all `req_ready` bits are 0 and the FSM stays in IDLE.
- **START:** `o_tx_start` = 1 for exactly this cycle. Clear the watchdog counter, then move to WAIT.
- **WAIT:** the watchdog counter increments each cycle.
  - `i_tx_done` moves the FSM to IDLE.
  - If the counter reaches `TIMEOUT_CYCLES-1` with no done, set `timeout_err` and move to IDLE.
  - If done and the timeout limit occur in the same cycle, done wins and `timeout_err` is not set.
- `i_tx_done` in IDLE or START is ignored.
- `req_ready` is 0 outside IDLE.
- A requester may drop `req_valid` before it is granted, with no side effects. It must hold `req_data` stable while `req_valid` is high.
- `err_clr` clears `timeout_err`. If `err_clr` and a new timeout occur in the same cycle, the set wins.
- Watchdog counter width is clog2(`TIMEOUT_CYCLES`). The counter saturates and never wraps.

## Timing
- **Reset values:**
  - state IDLE, `req_ready` = 0, `o_tx_start` = 0, `o_tx_byte` = 0
  - `busy` = 0, `grant_id` = 0, `timeout_err` = 0, counter = 0
  - `last` = N_REQ-1, so requester 0 has first priority
- **Latency:** grant edge → `o_tx_start` high in the next cycle (1 cycle). `busy` rises in the same cycle as `o_tx_start`.
- **Back-to-back:** done sampled at cycle t → IDLE at t+1 with `req_ready` possible at t+1 → next `o_tx_start` at t+2.
- **Reset asserted mid-frame:** all outputs return to their reset values immediately (asynchronous). A half-sent frame is not resumed. Grant order restarts from requester 0.
- A requester that keeps `req_valid` high while others are also valid waits at most N_REQ-1 grants.

## Test plan
- **Single request:** requester 2 asserts valid with byte 0xA5; in IDLE → `req_ready` = 0b0100 for one cycle, `o_tx_start` pulses one cycle later with `o_tx_byte` = 0xA5, `grant_id` = 2; done pulse → `busy` falls the following cycle.
- **Round-robin fairness:** all four requesters are held valid with bytes 0x10..0x13 and done is returned 20 cycles after each start → launch order is 0,1,2,3,0 and the spacing from each done to the next `o_tx_start` is exactly 2 cycles.
- **Timeout:** set TIMEOUT_CYCLES = 64 and never pulse done → `timeout_err` rises 64 cycles after `o_tx_start`, the FSM returns to IDLE and the next requester is granted. `err_clr` then clears the flag.
- **Simultaneous done and timeout:** done is pulsed in the same cycle the counter reaches 63 → `timeout_err` stays 0.
- **Stray done:** done is pulsed in IDLE and in START → no state change and no extra grant.
- **Reset mid-frame:** `rst_n` is pulled low during WAIT → `busy`, `o_tx_byte` and `grant_id` read 0 asynchronously; after release with requesters 1 and 3 valid, requester 1 is granted first.
